// File: rtl/conv_engine_stream_pkg.sv
// Shared types, default parameter values and arithmetic helpers for conv_engine_stream.
package conv_engine_stream_pkg;

  localparam int unsigned DefWeightWidth  = 8;
  localparam int unsigned DefImageWidth   = 16;
  localparam int unsigned DefImageNb      = 3;
  localparam int unsigned DefKernelWidth  = 3;
  localparam int unsigned DefKernelHeight = 3;

  typedef enum logic [1:0] {LdEmpty, LdLoading, LdFull} load_state_e;

  function automatic int unsigned acc_width(input int unsigned iw, input int unsigned ww,
                                            input int unsigned knb);
    return iw + ww + $clog2(knb);
  endfunction

  // LSB of lane `lane` within kernel row `row` of a packed image beat.
  function automatic int unsigned lane_lsb(input int unsigned row, input int unsigned lane,
                                           input int unsigned iw, input int unsigned nb);
    return (row * nb + lane) * iw;
  endfunction

  // Arithmetic right shift (toward -inf) then clamp to an iw-bit signed range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input logic [7:0] sh,
                                                   input int unsigned iw);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> sh;
    hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One lane of the convolution: S1 registers all tap products, S2 registers the adder-tree sum.
module conv_mac_lane
  import conv_engine_stream_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DefImageWidth,
  parameter int unsigned WEIGHT_WIDTH = DefWeightWidth,
  parameter int unsigned KERNEL_NB    = DefKernelWidth * DefKernelHeight,
  parameter int unsigned ACC_WIDTH    = acc_width(DefImageWidth, DefWeightWidth,
                                                  DefKernelWidth * DefKernelHeight)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic [KERNEL_NB*IMAGE_WIDTH-1:0]  pix_i,
  input  logic [KERNEL_NB*WEIGHT_WIDTH-1:0] wgt_i,
  output logic signed [ACC_WIDTH-1:0]       sum_o
);

  localparam int unsigned ProdW = IMAGE_WIDTH + WEIGHT_WIDTH;

  logic signed [ProdW-1:0]     prod_q [KERNEL_NB];
  logic signed [ACC_WIDTH-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < int'(KERNEL_NB); k++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(KERNEL_NB); k++) begin
        prod_q[k] <= '0;
      end
      sum_q <= '0;
    end else if (en_i) begin
      for (int k = 0; k < int'(KERNEL_NB); k++) begin
        prod_q[k] <= ProdW'($signed(pix_i[k*IMAGE_WIDTH +: IMAGE_WIDTH])) *
                     ProdW'($signed(wgt_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      end
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv_engine_stream.sv
// Streaming 2-D convolution with double-buffered kernel and ready/valid streams.
// Define CONV_ENGINE_STREAM_RELU_EN to clamp negative results to zero.
module conv_engine_stream
  import conv_engine_stream_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH  = DefWeightWidth,
  parameter int unsigned IMAGE_WIDTH   = DefImageWidth,
  parameter int unsigned IMAGE_NB      = DefImageNb,
  parameter int unsigned KERNEL_WIDTH  = DefKernelWidth,
  parameter int unsigned KERNEL_HEIGHT = DefKernelHeight
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [7:0]                                    cfg_shift_i,
  input  logic                                          cfg_valid_i,
  input  logic [WEIGHT_WIDTH-1:0]                       weight_i,
  input  logic                                          weight_valid_i,
  output logic                                          weight_ready_o,
  input  logic [IMAGE_WIDTH*IMAGE_NB*KERNEL_HEIGHT-1:0] image_i,
  input  logic                                          image_last_i,
  input  logic                                          image_valid_i,
  output logic                                          image_ready_o,
  output logic [IMAGE_WIDTH*IMAGE_NB-1:0]               result_o,
  output logic                                          result_valid_o,
  input  logic                                          result_ready_i
);

  localparam int unsigned KNB    = KERNEL_WIDTH * KERNEL_HEIGHT;
  localparam int unsigned AccW   = acc_width(IMAGE_WIDTH, WEIGHT_WIDTH, KNB);
  localparam int unsigned WcntW  = (KNB > 1) ? $clog2(KNB) : 1;
  localparam int unsigned FillW  = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;

  load_state_e                ld_q, ld_d;
  logic [WcntW-1:0]           wcnt_q, wcnt_d;
  logic signed [WEIGHT_WIDTH-1:0] shadow_q [KNB];
  logic signed [WEIGHT_WIDTH-1:0] active_q [KNB];
  logic                       active_valid_q;
  logic [7:0]                 cfg_q, sh0_q, sh1_q, sh2_q;
  logic [FillW-1:0]           fill_q;
  logic signed [IMAGE_WIDTH-1:0] win_q [KERNEL_WIDTH][KERNEL_HEIGHT][IMAGE_NB];
  logic                       v0_q, v1_q, v2_q, rv_q;
  logic [IMAGE_WIDTH*IMAGE_NB-1:0] res_q, res_d;
  logic signed [AccW-1:0]     lane_sum [IMAGE_NB];
  logic [KNB*WEIGHT_WIDTH-1:0] wgt_flat;

  logic shadow_full, stall, advance, swap, w_acc, img_acc, fire;

  assign shadow_full    = (ld_q == LdFull);
  assign stall          = rv_q && !result_ready_i;
  assign advance        = !stall;
  // Hold the swap while a stalled firing beat still needs the old kernel in S1.
  assign swap           = shadow_full && (fill_q == '0) && !(v0_q && stall);
  assign weight_ready_o = !shadow_full;
  assign w_acc          = weight_valid_i && weight_ready_o;
  assign image_ready_o  = active_valid_q && !stall && !swap;
  assign img_acc        = image_valid_i && image_ready_o;
  assign fire           = (fill_q >= FillW'(KERNEL_WIDTH - 1));

  always_comb begin
    ld_d   = ld_q;
    wcnt_d = wcnt_q;
    unique case (ld_q)
      LdEmpty, LdLoading: begin
        if (w_acc) begin
          if (wcnt_q == WcntW'(KNB - 1)) begin
            ld_d   = LdFull;
            wcnt_d = '0;
          end else begin
            ld_d   = LdLoading;
            wcnt_d = wcnt_q + WcntW'(1);
          end
        end
      end
      LdFull: begin
        if (swap) ld_d = LdEmpty;
      end
      default: ld_d = LdEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_q   <= LdEmpty;
      wcnt_q <= '0;
    end else begin
      ld_q   <= ld_d;
      wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(KNB); k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      active_valid_q <= 1'b0;
    end else begin
      if (w_acc) shadow_q[wcnt_q] <= weight_i;
      if (swap) begin
        active_q       <= shadow_q;
        active_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      sh0_q  <= '0;
      fill_q <= '0;
      for (int c = 0; c < int'(KERNEL_WIDTH); c++) begin
        for (int r = 0; r < int'(KERNEL_HEIGHT); r++) begin
          for (int i = 0; i < int'(IMAGE_NB); i++) begin
            win_q[c][r][i] <= '0;
          end
        end
      end
    end else begin
      if (cfg_valid_i) cfg_q <= cfg_shift_i;
      if (img_acc) begin
        for (int c = 0; c < int'(KERNEL_WIDTH) - 1; c++) begin
          win_q[c] <= win_q[c+1];
        end
        for (int r = 0; r < int'(KERNEL_HEIGHT); r++) begin
          for (int i = 0; i < int'(IMAGE_NB); i++) begin
            win_q[KERNEL_WIDTH-1][r][i] <=
              image_i[lane_lsb(r, i, IMAGE_WIDTH, IMAGE_NB) +: IMAGE_WIDTH];
          end
        end
        if (image_last_i) begin
          fill_q <= '0;
        end else if (!fire) begin
          fill_q <= fill_q + FillW'(1);
        end
        sh0_q <= cfg_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      rv_q  <= 1'b0;
      sh1_q <= '0;
      sh2_q <= '0;
      res_q <= '0;
    end else if (advance) begin
      v0_q  <= img_acc && fire;
      v1_q  <= v0_q;
      v2_q  <= v1_q;
      rv_q  <= v2_q;
      sh1_q <= sh0_q;
      sh2_q <= sh1_q;
      if (v2_q) res_q <= res_d;
    end
  end

  for (genvar k = 0; k < int'(KNB); k++) begin : g_wgt
    assign wgt_flat[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = active_q[k];
  end

  for (genvar i = 0; i < int'(IMAGE_NB); i++) begin : g_lane
    logic [KNB*IMAGE_WIDTH-1:0] pix;
    for (genvar r = 0; r < int'(KERNEL_HEIGHT); r++) begin : g_row
      for (genvar c = 0; c < int'(KERNEL_WIDTH); c++) begin : g_col
        assign pix[(r*KERNEL_WIDTH+c)*IMAGE_WIDTH +: IMAGE_WIDTH] = win_q[c][r][i];
      end
    end
    conv_mac_lane #(
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .KERNEL_NB    (KNB),
      .ACC_WIDTH    (AccW)
    ) u_mac (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (advance),
      .pix_i (pix),
      .wgt_i (wgt_flat),
      .sum_o (lane_sum[i])
    );
  end

  function automatic logic [IMAGE_WIDTH-1:0] s3_lane(input logic signed [AccW-1:0] sum,
                                                     input logic [7:0] sh);
    logic signed [63:0] s;
    s = sat_shift(64'(sum), sh, IMAGE_WIDTH);
`ifdef CONV_ENGINE_STREAM_RELU_EN
    if (s < 0) s = '0;
`else
    s = s;
`endif
    return s[IMAGE_WIDTH-1:0];
  endfunction

  always_comb begin
    res_d = '0;
    for (int i = 0; i < int'(IMAGE_NB); i++) begin
      res_d[i*IMAGE_WIDTH +: IMAGE_WIDTH] = s3_lane(lane_sum[i], sh2_q);
    end
  end

  assign result_o       = res_q;
  assign result_valid_o = rv_q;

endmodule
